// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the MEM/WB boundary: WB control field
// positions, the hardwired zero register and default datapath widths.
package wb_regfile_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;

  // Bit positions inside the 2-bit WB control field carried through MEM/WB
  localparam int unsigned WB_REGWRITE = 1;
  localparam int unsigned WB_MEMTOREG = 0;
  localparam int unsigned WB_CTRL_W   = 2;

  localparam int unsigned REG_ZERO = 0;

  typedef logic [WB_CTRL_W-1:0] wb_ctrl_t;

endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register storage: one synchronous write port, two
// combinational read ports, asynchronous clear.
module regfile_2r1w #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [DATA_WIDTH-1:0] rdata_a,
  output logic [DATA_WIDTH-1:0] rdata_b
);

  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage plus register file: selects the writeback value, commits it,
// serves the decode read ports with same-cycle bypass and exports the
// current/previous commits to the forwarding unit.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  wb_ctrl_t              WB,
  input  logic [ADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0] memData,
  input  logic [DATA_WIDTH-1:0] ALUData,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  output logic [DATA_WIDTH-1:0] rsData,
  output logic [DATA_WIDTH-1:0] rtData,
  output logic                  wbValid,
  output logic [ADDR_WIDTH-1:0] wbAddr,
  output logic [DATA_WIDTH-1:0] wbData,
  output logic                  prevWbValid,
  output logic [ADDR_WIDTH-1:0] prevWbAddr,
  output logic [DATA_WIDTH-1:0] prevWbData
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] rf_rs;
  logic [DATA_WIDTH-1:0] rf_rt;

  assign wbData  = WB[WB_MEMTOREG] ? memData : ALUData;
  assign wbValid = WB[WB_REGWRITE] && (rd != ZERO_ADDR);
  assign wbAddr  = rd;

  regfile_2r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_rf (
    .clock   (clock),
    .reset   (reset),
    .we      (wbValid),
    .waddr   (rd),
    .wdata   (wbData),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rf_rs),
    .rdata_b (rf_rt)
  );

  // Write-before-read bypass; r0 always reads as zero
  always_comb begin
    rsData = rf_rs;
    rtData = rf_rt;
    if (rs == ZERO_ADDR) begin
      rsData = '0;
    end else if (wbValid && (rd == rs)) begin
      rsData = wbData;
    end
    if (rt == ZERO_ADDR) begin
      rtData = '0;
    end else if (wbValid && (rd == rt)) begin
      rtData = wbData;
    end
  end

  // Last committed write; address/data hold across idle cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prevWbValid <= 1'b0;
      prevWbAddr  <= '0;
      prevWbData  <= '0;
    end else begin
      prevWbValid <= wbValid;
      if (wbValid) begin
        prevWbAddr <= rd;
        prevWbData <= wbData;
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: table of vectors with hand-computed
// expectations, a queue of post-edge expectations, and reset sequences.
module tb_wb_regfile;

  logic        clock;
  logic        reset;
  logic [1:0]  WB;
  logic [4:0]  rd;
  logic [31:0] memData;
  logic [31:0] ALUData;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic        wbValid;
  logic [4:0]  wbAddr;
  logic [31:0] wbData;
  logic        prevWbValid;
  logic [4:0]  prevWbAddr;
  logic [31:0] prevWbData;

  wb_regfile dut (
    .clock       (clock),
    .reset       (reset),
    .WB          (WB),
    .rd          (rd),
    .memData     (memData),
    .ALUData     (ALUData),
    .rs          (rs),
    .rt          (rt),
    .rsData      (rsData),
    .rtData      (rtData),
    .wbValid     (wbValid),
    .wbAddr      (wbAddr),
    .wbData      (wbData),
    .prevWbValid (prevWbValid),
    .prevWbAddr  (prevWbAddr),
    .prevWbData  (prevWbData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  wb;
    logic [4:0]  rd;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] ers;
    logic [31:0] ert;
    logic        ev;
    logic [31:0] ewd;
    logic        epv;
    logic [4:0]  epa;
    logic [31:0] epd;
  } vec_t;

  typedef struct {
    logic        pv;
    logic [4:0]  pa;
    logic [31:0] pd;
  } post_t;

  localparam int NVEC = 13;
  vec_t  vecs [NVEC];
  post_t sb [$];
  int    nvec = 0;
  int    nerr = 0;

  function automatic vec_t mk(input logic [1:0] wb, input logic [4:0] rd_i,
                              input logic [31:0] mem, input logic [31:0] alu,
                              input logic [4:0] rs_i, input logic [4:0] rt_i,
                              input logic [31:0] ers, input logic [31:0] ert,
                              input logic ev, input logic [31:0] ewd,
                              input logic epv, input logic [4:0] epa,
                              input logic [31:0] epd);
    vec_t v;
    v.wb = wb; v.rd = rd_i; v.mem = mem; v.alu = alu; v.rs = rs_i; v.rt = rt_i;
    v.ers = ers; v.ert = ert; v.ev = ev; v.ewd = ewd;
    v.epv = epv; v.epa = epa; v.epd = epd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [4:0] rd_i,
                       input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] rs_i, input logic [4:0] rt_i);
    WB = wb; rd = rd_i; memData = mem; ALUData = alu; rs = rs_i; rt = rt_i;
  endtask

  task automatic push_post(input logic pv, input logic [4:0] pa, input logic [31:0] pd);
    post_t p;
    p.pv = pv; p.pa = pa; p.pd = pd;
    sb.push_back(p);
  endtask

  task automatic check_post(input string tag);
    post_t p;
    if (sb.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      p = sb.pop_front();
      chk({tag, " prevWbValid"}, 32'(prevWbValid), 32'(p.pv));
      chk({tag, " prevWbAddr"},  32'(prevWbAddr),  32'(p.pa));
      chk({tag, " prevWbData"},  prevWbData,       p.pd);
    end
  endtask

  initial begin
    vecs[0]  = mk(2'b10, 5'd3,  32'h1111_1111, 32'hDEAD_BEEF, 5'd3,  5'd0,
                  32'hDEAD_BEEF, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1, 5'd3, 32'hDEAD_BEEF);
    vecs[1]  = mk(2'b00, 5'd0,  32'h0, 32'h0, 5'd3, 5'd3,
                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 5'd3, 32'hDEAD_BEEF);
    vecs[2]  = mk(2'b11, 5'd7,  32'hCAFE_F00D, 32'h1234_5678, 5'd7, 5'd7,
                  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D, 1'b1, 5'd7, 32'hCAFE_F00D);
    vecs[3]  = mk(2'b00, 5'd0,  32'h0, 32'h0, 5'd7, 5'd3,
                  32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 5'd7, 32'hCAFE_F00D);
    vecs[4]  = mk(2'b10, 5'd0,  32'h0, 32'hFFFF_FFFF, 5'd0, 5'd3,
                  32'h0, 32'hDEAD_BEEF, 1'b0, 32'hFFFF_FFFF, 1'b0, 5'd7, 32'hCAFE_F00D);
    vecs[5]  = mk(2'b10, 5'd4,  32'h0, 32'h99, 5'd0, 5'd4,
                  32'h0, 32'h99, 1'b1, 32'h99, 1'b1, 5'd4, 32'h99);
    vecs[6]  = mk(2'b01, 5'd4,  32'h55, 32'h0, 5'd4, 5'd4,
                  32'h99, 32'h99, 1'b0, 32'h55, 1'b0, 5'd4, 32'h99);
    vecs[7]  = mk(2'b00, 5'd0,  32'h0, 32'h0, 5'd0, 5'd4,
                  32'h0, 32'h99, 1'b0, 32'h0, 1'b0, 5'd4, 32'h99);
    vecs[8]  = mk(2'b10, 5'd9,  32'h0, 32'h1, 5'd9, 5'd0,
                  32'h1, 32'h0, 1'b1, 32'h1, 1'b1, 5'd9, 32'h1);
    vecs[9]  = mk(2'b10, 5'd9,  32'h0, 32'h2, 5'd9, 5'd9,
                  32'h2, 32'h2, 1'b1, 32'h2, 1'b1, 5'd9, 32'h2);
    vecs[10] = mk(2'b00, 5'd0,  32'h0, 32'h0, 5'd9, 5'd9,
                  32'h2, 32'h2, 1'b0, 32'h0, 1'b0, 5'd9, 32'h2);
    vecs[11] = mk(2'b11, 5'd31, 32'hA5A5_A5A5, 32'h0, 5'd31, 5'd30,
                  32'hA5A5_A5A5, 32'h0, 1'b1, 32'hA5A5_A5A5, 1'b1, 5'd31, 32'hA5A5_A5A5);
    vecs[12] = mk(2'b00, 5'd0,  32'h0, 32'h0, 5'd31, 5'd7,
                  32'hA5A5_A5A5, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b0, 5'd31, 32'hA5A5_A5A5);

    reset = 1'b1;
    drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd3, 5'd31);
    #12;
    chk("reset prevWbValid", 32'(prevWbValid), 32'h0);
    chk("reset prevWbAddr",  32'(prevWbAddr),  32'h0);
    chk("reset prevWbData",  prevWbData,       32'h0);
    chk("reset rsData",      rsData,           32'h0);
    chk("reset rtData",      rtData,           32'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].wb, vecs[i].rd, vecs[i].mem, vecs[i].alu, vecs[i].rs, vecs[i].rt);
      #1;
      chk($sformatf("v%0d rsData", i),  rsData,          vecs[i].ers);
      chk($sformatf("v%0d rtData", i),  rtData,          vecs[i].ert);
      chk($sformatf("v%0d wbValid", i), 32'(wbValid),    32'(vecs[i].ev));
      chk($sformatf("v%0d wbData", i),  wbData,          vecs[i].ewd);
      chk($sformatf("v%0d wbAddr", i),  32'(wbAddr),     32'(vecs[i].rd));
      // back-to-back: the second write to r9 still sees the first as prev
      if (i == 9) chk("b2b prevWbData", prevWbData, 32'h1);
      push_post(vecs[i].epv, vecs[i].epa, vecs[i].epd);
      tick();
      check_post($sformatf("v%0d", i));
    end

    // Mid-run asynchronous reset after committing r5
    drive(2'b10, 5'd5, 32'h0, 32'h1234, 5'd0, 5'd0);
    tick();
    drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd5, 5'd3);
    #1;
    chk("pre-reset r5", rsData, 32'h1234);
    chk("pre-reset prevWbValid", 32'(prevWbValid), 32'h1);
    #1;
    reset = 1'b1;
    #1;
    chk("async reset r5", rsData, 32'h0);
    chk("async reset r3", rtData, 32'h0);
    push_post(1'b0, 5'd0, 32'h0);
    check_post("async reset");

    // Write presented under reset bypasses but never commits
    drive(2'b10, 5'd6, 32'h0, 32'h77, 5'd6, 5'd0);
    #1;
    chk("reset bypass rsData", rsData, 32'h77);
    chk("reset wbValid", 32'(wbValid), 32'h1);
    push_post(1'b0, 5'd0, 32'h0);
    tick();
    check_post("reset edge");
    #2;
    reset = 1'b0;
    drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd6, 5'd5);
    #1;
    chk("lost write r6", rsData, 32'h0);
    chk("cleared r5", rtData, 32'h0);

    // First write after release commits normally
    tick();
    drive(2'b10, 5'd5, 32'h0, 32'hABCD, 5'd0, 5'd0);
    push_post(1'b1, 5'd5, 32'hABCD);
    tick();
    check_post("post-reset write");
    drive(2'b00, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5);
    #1;
    chk("post-reset r5 rs", rsData, 32'hABCD);
    chk("post-reset r5 rt", rtData, 32'hABCD);

    if (sb.size() != 0) begin
      nvec++;
      nerr++;
      $display("FAIL scoreboard leftover: got %0d expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
